// File: rtl/sdiv_iter.sv
// Iterative signed divider: a 2*SIZE-bit signed dividend divided by a SIZE-bit
// signed divisor. Restoring long division on magnitudes, one quotient bit per
// cycle, followed by a sign/overflow fix-up cycle. Valid/ready handshake on both
// sides with a single division in flight.
module sdiv_iter #(
  parameter int SIZE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*SIZE-1:0] a,
  input  logic [SIZE-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   quotient,
  output logic [SIZE-1:0]   remainder,
  output logic              overflow,
  output logic              div_by_zero
);

  localparam int DW    = 2 * SIZE;
  localparam int CNT_W = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  // Dividend magnitude; quotient bits shift in at the LSB as dividend bits leave the MSB.
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [SIZE-1:0]   dsr_q, dsr_d;        // divisor magnitude
  logic [SIZE-1:0]   rem_q, rem_d;        // running remainder, always < divisor magnitude
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   quo_q, quo_d, rmd_q, rmd_d;
  logic              ovf_q, ovf_d, dbz_q, dbz_d;

  // Partial remainder for this iteration is SIZE+1 bits: remainder shifted left
  // with the next dividend bit. Since the stored remainder is below the divisor,
  // the restored/subtracted result always fits back into SIZE bits.
  logic [SIZE:0]     trial;
  logic              ge;
  logic [SIZE-1:0]   diff;
  logic [DW-1:0]     q_full;
  logic [SIZE:0]     q_hi;

  assign trial  = {rem_q, dvd_q[DW-1]};
  assign ge     = (trial >= {1'b0, dsr_q});
  assign diff   = trial[SIZE-1:0] - dsr_q;
  assign q_full = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
  // Quotient fits in SIZE signed bits only if its top SIZE+1 bits are all equal.
  assign q_hi   = q_full[DW-1:SIZE-1];

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d  = a[DW-1];
          sb_d  = b[SIZE-1];
          dvd_d = a[DW-1] ? -a : a;
          dsr_d = b[SIZE-1] ? -b : b;
          rem_d = '0;
          cnt_d = CNT_W'(DW - 1);
          if (b == '0) begin
            // Division by zero skips the iteration entirely.
            quo_d   = '0;
            rmd_d   = '0;
            ovf_d   = 1'b1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = {dvd_q[DW-2:0], ge};
        rem_d = ge ? diff : trial[SIZE-1:0];
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        // Truncation toward zero; remainder takes the sign of the dividend.
        quo_d   = q_full[SIZE-1:0];
        rmd_d   = sa_q ? -rem_q : rem_q;
        ovf_d   = q_full[DW-1] ? ~&q_hi : |q_hi;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule
